// File: rtl/sdram_arbiter.sv
// Arbitrates one SDRAM controller port between a ROM download writer and four
// read clients; each client keeps a one-entry hit register of its last read.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dl_wr,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [DATA_WIDTH-1:0] dl_data,
    output logic                  dl_busy,
    input  logic                  c0_rd,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    output logic [DATA_WIDTH-1:0] c0_q,
    output logic                  c0_valid,
    input  logic                  c1_rd,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    output logic [DATA_WIDTH-1:0] c1_q,
    output logic                  c1_valid,
    input  logic                  c2_rd,
    input  logic [ADDR_WIDTH-1:0] c2_addr,
    output logic [DATA_WIDTH-1:0] c2_q,
    output logic                  c2_valid,
    input  logic                  c3_rd,
    input  logic [ADDR_WIDTH-1:0] c3_addr,
    output logic [DATA_WIDTH-1:0] c3_q,
    output logic                  c3_valid,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  sdram_valid,
    input  logic [DATA_WIDTH-1:0] sdram_q
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [3:0]            rd_vec;
    logic [ADDR_WIDTH-1:0] rd_addr [4];

    logic [3:0]            pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q [4];
    logic [ADDR_WIDTH-1:0] pend_addr_d [4];
    logic [ADDR_WIDTH-1:0] tag_q [4];
    logic [ADDR_WIDTH-1:0] tag_d [4];
    logic [3:0]            tag_v_q, tag_v_d;
    logic [DATA_WIDTH-1:0] cq_q [4];
    logic [DATA_WIDTH-1:0] cq_d [4];
    logic [3:0]            cvalid_q, cvalid_d;

    logic                  dl_pend_q, dl_pend_d;
    logic [ADDR_WIDTH-1:0] dl_addr_q, dl_addr_d;
    logic [DATA_WIDTH-1:0] dl_data_q, dl_data_d;
    logic                  dl_busy_q, dl_busy_d;

    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            rr_q, rr_d;
    logic [1:0]            gnt_q, gnt_d;

    logic                  found;
    logic [1:0]            sel;
    logic [1:0]            cand;

    assign rd_vec     = {c3_rd, c2_rd, c1_rd, c0_rd};
    assign rd_addr[0] = c0_addr;
    assign rd_addr[1] = c1_addr;
    assign rd_addr[2] = c2_addr;
    assign rd_addr[3] = c3_addr;

    assign c0_q     = cq_q[0];
    assign c1_q     = cq_q[1];
    assign c2_q     = cq_q[2];
    assign c3_q     = cq_q[3];
    assign c0_valid = cvalid_q[0];
    assign c1_valid = cvalid_q[1];
    assign c2_valid = cvalid_q[2];
    assign c3_valid = cvalid_q[3];

    assign dl_busy    = dl_busy_q;
    assign sdram_req  = req_q;
    assign sdram_we   = we_q;
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        tag_d       = tag_q;
        tag_v_d     = tag_v_q;
        cq_d        = cq_q;
        cvalid_d    = '0;
        dl_pend_d   = dl_pend_q;
        dl_addr_d   = dl_addr_q;
        dl_data_d   = dl_data_q;
        dl_busy_d   = dl_busy_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        found       = 1'b0;
        sel         = rr_q;
        cand        = '0;

        // Round-robin search starting at rr_q
        for (int k = 0; k < 4; k++) begin
            cand = rr_q + 2'(k);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (dl_pend_q) begin
                    req_d     = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = dl_addr_q;
                    data_d    = dl_data_q;
                    dl_pend_d = 1'b0;
                    state_d   = S_REQ;
                end else if (found) begin
                    req_d       = 1'b1;
                    we_d        = 1'b0;
                    addr_d      = pend_addr_q[sel];
                    pend_d[sel] = 1'b0;
                    rr_d        = sel + 2'd1;
                    gnt_d       = sel;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        // Download may have rewritten any cached word
                        dl_busy_d = 1'b0;
                        tag_v_d   = '0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sdram_valid) begin
                    cq_d[gnt_q]     = sdram_q;
                    cvalid_d[gnt_q] = 1'b1;
                    tag_d[gnt_q]    = addr_q;
                    tag_v_d[gnt_q]  = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // New strobes compare against the registered tag; a set pending bit wins over a grant clear
        for (int i = 0; i < 4; i++) begin
            if (rd_vec[i]) begin
                if (tag_v_q[i] && (rd_addr[i] == tag_q[i])) begin
                    cvalid_d[i] = 1'b1;
                end else begin
                    pend_d[i]      = 1'b1;
                    pend_addr_d[i] = rd_addr[i];
                end
            end
        end

        if (dl_wr) begin
            dl_pend_d = 1'b1;
            dl_addr_d = dl_addr;
            dl_data_d = dl_data;
            dl_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            tag_v_q   <= '0;
            cvalid_q  <= '0;
            dl_pend_q <= 1'b0;
            dl_addr_q <= '0;
            dl_data_q <= '0;
            dl_busy_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                pend_addr_q[i] <= '0;
                tag_q[i]       <= '0;
                cq_q[i]        <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            tag_q       <= tag_d;
            tag_v_q     <= tag_v_d;
            cq_q        <= cq_d;
            cvalid_q    <= cvalid_d;
            dl_pend_q   <= dl_pend_d;
            dl_addr_q   <= dl_addr_d;
            dl_data_q   <= dl_data_d;
            dl_busy_q   <= dl_busy_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: cycle table for hit/miss and round robin,
// then hand sequences for download priority, reset in WAIT, overwrite and queueing.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_wr;
    logic [22:0] dl_addr;
    logic [31:0] dl_data;
    logic        dl_busy;
    logic        c0_rd, c1_rd, c2_rd, c3_rd;
    logic [22:0] c0_addr, c1_addr, c2_addr, c3_addr;
    logic [31:0] c0_q, c1_q, c2_q, c3_q;
    logic        c0_valid, c1_valid, c2_valid, c3_valid;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_we, sdram_req;
    logic        sdram_ack, sdram_valid;
    logic [31:0] sdram_q;

    int checks = 0;
    int errors = 0;

    logic [3:0]  cv;
    logic [31:0] cq [4];
    logic [33:0] evq [$];

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_WIDTH(23), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
        .c0_rd(c0_rd), .c0_addr(c0_addr), .c0_q(c0_q), .c0_valid(c0_valid),
        .c1_rd(c1_rd), .c1_addr(c1_addr), .c1_q(c1_q), .c1_valid(c1_valid),
        .c2_rd(c2_rd), .c2_addr(c2_addr), .c2_q(c2_q), .c2_valid(c2_valid),
        .c3_rd(c3_rd), .c3_addr(c3_addr), .c3_q(c3_q), .c3_valid(c3_valid),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .sdram_q(sdram_q)
    );

    assign cv    = {c3_valid, c2_valid, c1_valid, c0_valid};
    assign cq[0] = c0_q;
    assign cq[1] = c1_q;
    assign cq[2] = c2_q;
    assign cq[3] = c3_q;

    // Record every client data pulse as {client, data}
    always @(negedge clk) begin
        for (int n = 0; n < 4; n++)
            if (cv[n]) evq.push_back({2'(n), cq[n]});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  rd;
        logic [22:0] base;
        logic        ack;
        logic        val;
        logic [31:0] q;
        logic        e_req;
        logic [22:0] e_addr;
        logic [3:0]  e_v;
        logic [31:0] e_q;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rd, input logic [22:0] base,
                                input logic ack, input logic val, input logic [31:0] q,
                                input logic e_req, input logic [22:0] e_addr,
                                input logic [3:0] e_v, input logic [31:0] e_q);
        vec_t v;
        v.rst = rst; v.rd = rd; v.base = base; v.ack = ack; v.val = val; v.q = q;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_q = e_q;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic wait_req(input string nm, output bit ok);
        int n = 0;
        while (!sdram_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = sdram_req;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no sdram_req within 50 cycles, required a request", nm);
        end
    endtask

    // Plays the controller for one transaction
    task automatic serve(input logic we, input logic [22:0] a, input logic [31:0] wd,
                         input logic [31:0] rdv, input string nm);
        bit ok;
        wait_req(nm, ok);
        if (ok) begin
            chk({nm, "_we"}, sdram_we, we);
            chk({nm, "_addr"}, sdram_addr, a);
            if (we) chk({nm, "_data"}, sdram_data, wd);
            sdram_ack = 1'b1;
            @(negedge clk);
            sdram_ack = 1'b0;
            chk({nm, "_req_drop"}, sdram_req, 1'b0);
            if (!we) begin
                sdram_valid = 1'b1;
                sdram_q     = rdv;
                @(negedge clk);
                sdram_valid = 1'b0;
            end
        end
    endtask

    task automatic check_ev(input int idx, input logic [1:0] c, input logic [31:0] d, input string nm);
        if (idx >= evq.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d valid pulses seen, required pulse #%0d", nm, evq.size(), idx);
        end else begin
            chk(nm, evq[idx], {c, d});
        end
    endtask

    task automatic clear_inputs();
        dl_wr = 0; dl_addr = 0; dl_data = 0;
        c0_rd = 0; c1_rd = 0; c2_rd = 0; c3_rd = 0;
        c0_addr = 0; c1_addr = 0; c2_addr = 0; c3_addr = 0;
        sdram_ack = 0; sdram_valid = 0; sdram_q = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        evq.delete();
    endtask

    initial begin
        int seen;
        bit ok;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        vecs.push_back(mk(1, 4'b0000, 23'h000, 0, 0, 32'h0,        0, 23'h000, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0100, 23'h0FE, 0, 0, 32'h0,        0, 23'h000, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'h55,       1, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hDEADBEEF, 0, 23'h100, 4'b0100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        0, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0100, 23'h0FE, 0, 0, 32'h0,        0, 23'h100, 4'b0100, 32'hDEADBEEF));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        0, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 1, 32'h77,       0, 23'h100, 4'b0000, 32'h0));
        vecs.push_back(mk(1, 4'b0000, 23'h000, 0, 0, 32'h0,        0, 23'h000, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b1111, 23'h200, 0, 0, 32'h0,        0, 23'h000, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h200, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h200, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hA0,       0, 23'h200, 4'b0001, 32'hA0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h201, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h201, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hA1,       0, 23'h201, 4'b0010, 32'hA1));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h202, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h202, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hA2,       0, 23'h202, 4'b0100, 32'hA2));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h203, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h203, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hA3,       0, 23'h203, 4'b1000, 32'hA3));
        vecs.push_back(mk(0, 4'b1010, 23'h300, 0, 0, 32'h0,        0, 23'h203, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h301, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h301, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hB1,       0, 23'h301, 4'b0010, 32'hB1));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 0, 32'h0,        1, 23'h303, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 1, 0, 32'h0,        0, 23'h303, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 23'h000, 0, 1, 32'hB3,       0, 23'h303, 4'b1000, 32'hB3));

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            {c3_rd, c2_rd, c1_rd, c0_rd} = vecs[i].rd;
            c0_addr     = vecs[i].base;
            c1_addr     = vecs[i].base + 23'd1;
            c2_addr     = vecs[i].base + 23'd2;
            c3_addr     = vecs[i].base + 23'd3;
            sdram_ack   = vecs[i].ack;
            sdram_valid = vecs[i].val;
            sdram_q     = vecs[i].q;
            @(negedge clk);
            chk($sformatf("row%0d_req", i), sdram_req, vecs[i].e_req);
            chk($sformatf("row%0d_we", i), sdram_we, 1'b0);
            chk($sformatf("row%0d_addr", i), sdram_addr, vecs[i].e_addr);
            chk($sformatf("row%0d_valid", i), cv, vecs[i].e_v);
            for (int n = 0; n < 4; n++) begin
                if (vecs[i].e_v[n]) chk($sformatf("row%0d_c%0d_q", i, n), cq[n], vecs[i].e_q);
                if (vecs[i].rst) chk($sformatf("row%0d_c%0d_q_rst", i, n), cq[n], 32'h0);
            end
            if (vecs[i].rst) chk($sformatf("row%0d_busy_rst", i), dl_busy, 1'b0);
        end
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);

        // Download priority behind an in-flight read, then tag invalidation
        reset_dut();
        c2_rd = 1; c2_addr = 23'h500;
        @(negedge clk);
        c2_rd = 0;
        serve(0, 23'h500, 32'h0, 32'hC2C20001, "a_c2_fill");
        c0_rd = 1; c0_addr = 23'h010;
        @(negedge clk);
        c0_rd = 0;
        wait_req("a_c0_req", ok);
        chk("a_c0_addr", sdram_addr, 23'h010);
        dl_wr = 1; dl_addr = 23'h010; dl_data = 32'h12345678;
        c1_rd = 1; c1_addr = 23'h600;
        sdram_ack = 1;
        @(negedge clk);
        dl_wr = 0; c1_rd = 0; sdram_ack = 0;
        chk("a_busy_set", dl_busy, 1'b1);
        sdram_valid = 1; sdram_q = 32'h0C0C0C0C;
        @(negedge clk);
        sdram_valid = 0;
        serve(1, 23'h010, 32'h12345678, 32'h0, "a_dl");
        chk("a_busy_clr", dl_busy, 1'b0);
        serve(0, 23'h600, 32'h0, 32'h11110001, "a_c1");
        c2_rd = 1; c2_addr = 23'h500;
        @(negedge clk);
        c2_rd = 0;
        serve(0, 23'h500, 32'h0, 32'hC2C20002, "a_c2_reread");
        repeat (2) @(negedge clk);
        chk("a_ev_count", evq.size(), 4);
        check_ev(0, 2'd2, 32'hC2C20001, "a_ev0");
        check_ev(1, 2'd0, 32'h0C0C0C0C, "a_ev1");
        check_ev(2, 2'd1, 32'h11110001, "a_ev2");
        check_ev(3, 2'd2, 32'hC2C20002, "a_ev3");

        // Reset while waiting for read data; late valid must be dropped
        evq.delete();
        c1_rd = 1; c1_addr = 23'h030;
        @(negedge clk);
        c1_rd = 0;
        wait_req("d_c1_req", ok);
        sdram_ack = 1;
        @(negedge clk);
        sdram_ack = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("d_rst_req", sdram_req, 1'b0);
        chk("d_rst_we", sdram_we, 1'b0);
        chk("d_rst_addr", sdram_addr, 23'h0);
        chk("d_rst_data", sdram_data, 32'h0);
        chk("d_rst_busy", dl_busy, 1'b0);
        chk("d_rst_c1_q", c1_q, 32'h0);
        chk("d_rst_c2_q", c2_q, 32'h0);
        sdram_valid = 1; sdram_q = 32'hBAD0BAD0;
        @(negedge clk);
        sdram_valid = 0;
        repeat (4) @(negedge clk);
        chk("d_no_valid", evq.size(), 0);
        c0_rd = 1; c0_addr = 23'h900;
        c3_rd = 1; c3_addr = 23'h903;
        @(negedge clk);
        c0_rd = 0; c3_rd = 0;
        serve(0, 23'h900, 32'h0, 32'hD0000000, "d_rr_c0");
        serve(0, 23'h903, 32'h0, 32'hD0000003, "d_rr_c3");
        repeat (2) @(negedge clk);
        check_ev(0, 2'd0, 32'hD0000000, "d_ev0");
        check_ev(1, 2'd3, 32'hD0000003, "d_ev1");

        // Latest address wins while a request is still ungranted
        reset_dut();
        c1_rd = 1; c1_addr = 23'h700;
        @(negedge clk);
        c1_rd = 0;
        wait_req("b_c1_req", ok);
        c3_rd = 1; c3_addr = 23'h040;
        @(negedge clk);
        c3_addr = 23'h080;
        @(negedge clk);
        c3_rd = 0;
        serve(0, 23'h700, 32'h0, 32'h70007000, "b_c1");
        serve(0, 23'h080, 32'h0, 32'h80808080, "b_c3");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sdram_req) seen++;
        end
        chk("b_no_extra_req", seen, 0);
        chk("b_ev_count", evq.size(), 2);
        check_ev(0, 2'd1, 32'h70007000, "b_ev0");
        check_ev(1, 2'd3, 32'h80808080, "b_ev1");

        // Second read queued behind the client's in-flight read
        reset_dut();
        c0_rd = 1; c0_addr = 23'h010;
        @(negedge clk);
        c0_rd = 0;
        wait_req("c_c0_req", ok);
        chk("c_c0_addr", sdram_addr, 23'h010);
        sdram_ack = 1;
        @(negedge clk);
        sdram_ack = 0;
        c0_rd = 1; c0_addr = 23'h020;
        @(negedge clk);
        c0_rd = 0;
        sdram_valid = 1; sdram_q = 32'h10101010;
        @(negedge clk);
        sdram_valid = 0;
        serve(0, 23'h020, 32'h0, 32'h20202020, "c_c0_second");
        repeat (2) @(negedge clk);
        chk("c_ev_count", evq.size(), 2);
        check_ev(0, 2'd0, 32'h10101010, "c_ev0");
        check_ev(1, 2'd0, 32'h20202020, "c_ev1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between the ROM download path and four read clients (CPU program ROM, sound ROM, tile ROM, sprite ROM).
- Sits between the game core's ROM fetchers and the sdram controller, replacing direct wiring of sdram_addr/req/we.
- One outstanding SDRAM transaction at a time.
- Download writes have absolute priority. Reads are round-robin, with a one-entry hit register per read client.

Parameters:
ADDR_WIDTH, 23, SDRAM word address width
DATA_WIDTH, 32, SDRAM word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dl_wr  in  1  one-cycle strobe: write dl_data to dl_addr
dl_addr  in  ADDR_WIDTH  download word address
dl_data  in  DATA_WIDTH  download word
dl_busy  out  1  download write pending or in flight; dl_wr must not strobe while high
cN_rd  in  1  (N=0..3) one-cycle read strobe
cN_addr  in  ADDR_WIDTH  (N=0..3) read address, sampled with cN_rd
cN_q  out  DATA_WIDTH  (N=0..3) read data, held until next cN_valid
cN_valid  out  1  (N=0..3) one-cycle pulse: cN_q updated
sdram_addr  out  ADDR_WIDTH  to controller
sdram_data  out  DATA_WIDTH  to controller, write data
sdram_we  out  1  to controller, 1 = write
sdram_req  out  1  to controller, request
sdram_ack  in  1  from controller, request accepted (one-cycle pulse)
sdram_valid  in  1  from controller, read data valid (one-cycle pulse)
sdram_q  in  DATA_WIDTH  from controller, read data

Behaviour:
- Reset values:
  - All cN_q = 0; all cN_valid = 0.
  - sdram_req = 0, sdram_we = 0, sdram_addr = 0, sdram_data = 0.
  - dl_busy = 0.
  - State IDLE; round-robin pointer rr = 0.
  - All pending bits cleared; all tag-valid bits cleared.
- Per-client registers: pending bit, pending address, tag address, tag-valid bit.
- cN_rd strobe at edge t, with a tag hit (tag-valid and cN_addr == tag):
  - cN_valid = 1 at t+1, cN_q = cached data.
  - No SDRAM access.
- cN_rd strobe, tag miss:
  - Pending bit set and pending address latched at t.
  - If the client's pending request is not yet granted, the new address overwrites it (latest wins); only one cN_valid results.
  - If the client's previous request is in flight, the new request is queued; two cN_valid pulses result, in order.
- dl_wr strobe: sets the download pending bit, latches address and data, and sets dl_busy.
- All outputs are registered. Outputs to the controller change only on state transitions.
- FSM states:
  - IDLE:
    - If download pending: sdram_req = 1, sdram_we = 1, sdram_addr/sdram_data from the download latch; go to REQ.
    - Else, if any client pending: grant the first pending client searching rr, rr+1, rr+2, rr+3 (mod 4). Set sdram_req = 1, sdram_we = 0, sdram_addr = its pending address; clear its pending bit; rr = granted + 1 mod 4; go to REQ.
    - Earliest sdram_req is the cycle after the pending bit is set (rd at t, req high at t+1).
  - REQ:
    - Hold all request outputs until sdram_ack = 1.
    - On ack: sdram_req = 0 next cycle.
    - Write: clear dl_busy, clear all tag-valid bits, go to IDLE.
    - Read: go to WAIT.
  - WAIT:
    - On sdram_valid: cN_q = sdram_q and cN_valid = 1 for the granted client.
    - Tag = granted address, tag-valid = 1, go to IDLE.
- Latency, miss with an idle arbiter: cN_valid = controller latency + 3 cycles after cN_rd.
- Download never preempts an in-flight read; it wins at the next IDLE.
- sdram_ack or sdram_valid while in IDLE is ignored. sdram_valid in REQ is ignored.
- cN_rd in the same cycle as that client's cN_valid: tag compare uses the old tag.
- Reset mid-transaction: return to IDLE with sdram_req = 0 next cycle. Late ack/valid from the controller is discarded. No cN_valid pulses are generated.

Test Plan:
- Miss then hit: c2_rd at addr 0x000100; controller returns 0xDEADBEEF → c2_valid pulses once with c2_q = 0xDEADBEEF. A second c2_rd at 0x000100 → c2_valid at the next cycle, and sdram_req stays low.
- Round robin: c0..c3 strobe in the same cycle, rr = 0 → grant order 0, 1, 2, 3. Then c1 and c3 strobe together → c1 granted first (rr = 0 after wrap).
- Download priority: c0 read in flight, dl_wr at 0x000010 with data 0x12345678, c1 pending → after c0 completes, write issued with sdram_we = 1 before c1. dl_busy falls after ack. The c2 tag is invalidated: re-reading its prior address issues sdram_req.
- Overwrite: c3_rd at 0x40 then c3_rd at 0x80 before grant → single SDRAM read at 0x80 and a single c3_valid.
- Queue behind in-flight: c0_rd at 0x10, granted, then c0_rd at 0x20 during WAIT → two reads in order, two c0_valid pulses with the respective data.
- Reset in WAIT: assert reset one cycle, then sdram_valid → no cN_valid. All outputs at reset values; rr = 0.
